// File: rtl/iob_bootrom_loader.sv
// iob_bootrom_loader: AXI4 read initiator that copies a block of bootrom
// words into a local RAM through a simple write port.
// Optional feature: define IOB_BOOTROM_LOADER_CHECKSUM_EN to add checksum_o,
// a modulo-2^32 sum of every word copied during the last transfer.
module iob_bootrom_loader #(
   parameter int          DATA_W     = 32,
   parameter int          ADDR_W     = 11,
   parameter int          AXI_ID_W   = 1,
   parameter int          AXI_LEN_W  = 8,
   parameter int          MEM_ADDR_W = 10,
   parameter int unsigned ROM_BASE   = 0,
   parameter int          BURST_LEN  = 16
) (
   input  logic                  clk_i,
   input  logic                  cke_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [MEM_ADDR_W:0]   nwords_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [ADDR_W-1:0]     axi_araddr_o,
   output logic                  axi_arvalid_o,
   input  logic                  axi_arready_i,
   output logic [AXI_ID_W-1:0]   axi_arid_o,
   output logic [AXI_LEN_W-1:0]  axi_arlen_o,
   output logic [2:0]            axi_arsize_o,
   output logic [1:0]            axi_arburst_o,
   output logic [2:0]            axi_arprot_o,
   output logic [1:0]            axi_arlock_o,
   output logic [3:0]            axi_arcache_o,
   output logic [3:0]            axi_arqos_o,
   input  logic [DATA_W-1:0]     axi_rdata_i,
   input  logic [1:0]            axi_rresp_i,
   input  logic                  axi_rvalid_i,
   output logic                  axi_rready_o,
   input  logic [AXI_ID_W-1:0]   axi_rid_i,
   input  logic                  axi_rlast_i,
   output logic                  mem_we_o,
   output logic [MEM_ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
`ifdef IOB_BOOTROM_LOADER_CHECKSUM_EN
   output logic [DATA_W-1:0]     checksum_o,
`endif
   input  logic                  mem_ready_i
);

   localparam int CNT_W  = MEM_ADDR_W + 1;
   localparam int BEAT_W = AXI_LEN_W + 1;
   localparam int MIN_W  = (CNT_W > BEAT_W) ? CNT_W : BEAT_W;
   localparam int RA_W   = (ADDR_W > MEM_ADDR_W + 2) ? ADDR_W : MEM_ADDR_W + 2;
   localparam logic [CNT_W-1:0] MAX_WORDS = {1'b1, {MEM_ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      remaining_q, remaining_d;
   logic [MEM_ADDR_W-1:0] widx_q, widx_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [BEAT_W-1:0]     blen_q, blen_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
`ifdef IOB_BOOTROM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0]     checksum_q, checksum_d;
`endif

   logic [CNT_W-1:0]  nwords_clamped;
   logic [MIN_W-1:0]  rem_ext;
   logic [MIN_W-1:0]  burst_beats;
   logic [BEAT_W-1:0] burst_len_w;
   logic [RA_W-1:0]   rom_addr_ext;
   logic              beat_fire;
   logic              last_beat;
   logic              unused_rid;

   // Requests above the RAM size are clamped so RAM writes never alias.
   assign nwords_clamped = (nwords_i > MAX_WORDS) ? MAX_WORDS : nwords_i;

   assign rem_ext      = MIN_W'(remaining_q);
   assign burst_beats  = (rem_ext > MIN_W'(BURST_LEN)) ? MIN_W'(BURST_LEN) : rem_ext;
   assign burst_len_w  = BEAT_W'(burst_beats);
   assign rom_addr_ext = RA_W'(ROM_BASE) + RA_W'({widx_q, 2'b00});

   // AXI read address channel; fields are stable while in ADDR.
   assign axi_araddr_o  = rom_addr_ext[ADDR_W-1:0];
   assign axi_arvalid_o = (state_q == ADDR);
   assign axi_arlen_o   = AXI_LEN_W'(burst_len_w - BEAT_W'(1));
   assign axi_arid_o    = '0;
   assign axi_arsize_o  = 3'd2;
   assign axi_arburst_o = 2'b01;
   assign axi_arprot_o  = '0;
   assign axi_arlock_o  = '0;
   assign axi_arcache_o = '0;
   assign axi_arqos_o   = '0;

   // RAM backpressure passes straight through to rready; a stopped clock
   // must not let a beat be accepted that the state cannot record.
   assign axi_rready_o = (state_q == DATA) & mem_ready_i & cke_i;
   assign beat_fire    = axi_rvalid_i & axi_rready_o;
   assign last_beat    = (beat_q == (blen_q - BEAT_W'(1)));

   assign mem_we_o    = beat_fire;
   assign mem_addr_o  = widx_q;
   assign mem_wdata_o = axi_rdata_i;

   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign error_o = error_q;
`ifdef IOB_BOOTROM_LOADER_CHECKSUM_EN
   assign checksum_o = checksum_q;
`endif

   assign unused_rid = ^axi_rid_i;

   // Next-state and register-update logic for the copy sequencer.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      widx_d      = widx_q;
      beat_d      = beat_q;
      blen_d      = blen_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
`ifdef IOB_BOOTROM_LOADER_CHECKSUM_EN
      checksum_d  = checksum_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               remaining_d = nwords_clamped;
               widx_d      = '0;
               error_d     = 1'b0;
               busy_d      = 1'b1;
`ifdef IOB_BOOTROM_LOADER_CHECKSUM_EN
               checksum_d  = '0;
`endif
               state_d     = (nwords_clamped == '0) ? DONE : ADDR;
            end
         end
         ADDR: begin
            if (axi_arready_i) begin
               beat_d  = '0;
               blen_d  = burst_len_w;
               state_d = DATA;
            end
         end
         DATA: begin
            if (beat_fire) begin
               widx_d      = widx_q + MEM_ADDR_W'(1);
               remaining_d = remaining_q - CNT_W'(1);
               beat_d      = beat_q + BEAT_W'(1);
`ifdef IOB_BOOTROM_LOADER_CHECKSUM_EN
               checksum_d  = checksum_q + axi_rdata_i;
`endif
               if ((axi_rresp_i != 2'b00) || (axi_rlast_i != last_beat)) begin
                  error_d = 1'b1;
               end
               // The burst ends on the counted beat count, not on rlast.
               if (last_beat) begin
                  state_d = (remaining_q == CNT_W'(1)) ? DONE : ADDR;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers: synchronous reset wins over the clock enable.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         widx_q      <= '0;
         beat_q      <= '0;
         blen_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef IOB_BOOTROM_LOADER_CHECKSUM_EN
         checksum_q  <= '0;
`endif
      end else if (cke_i) begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         widx_q      <= widx_d;
         beat_q      <= beat_d;
         blen_q      <= blen_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
`ifdef IOB_BOOTROM_LOADER_CHECKSUM_EN
         checksum_q  <= checksum_d;
`endif
      end
   end

endmodule

// File: tb/tb_iob_bootrom_loader.sv
// Testbench for iob_bootrom_loader: randomized AXI slave with a scoreboard.
`timescale 1ns/1ps
module tb_iob_bootrom_loader;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 11;
   localparam int AXI_ID_W   = 1;
   localparam int AXI_LEN_W  = 8;
   localparam int MEM_ADDR_W = 10;
   localparam int BURST_LEN  = 16;
   localparam int ROM_WORDS  = 512;
   localparam int RAM_WORDS  = 1024;

   logic                  clk, cke_i, rst_i, start_i;
   logic [MEM_ADDR_W:0]   nwords_i;
   logic                  busy_o, done_o, error_o;
   logic [ADDR_W-1:0]     axi_araddr_o;
   logic                  axi_arvalid_o, axi_arready_i;
   logic [AXI_ID_W-1:0]   axi_arid_o;
   logic [AXI_LEN_W-1:0]  axi_arlen_o;
   logic [2:0]            axi_arsize_o, axi_arprot_o;
   logic [1:0]            axi_arburst_o, axi_arlock_o;
   logic [3:0]            axi_arcache_o, axi_arqos_o;
   logic [DATA_W-1:0]     axi_rdata_i;
   logic [1:0]            axi_rresp_i;
   logic                  axi_rvalid_i, axi_rready_o, axi_rlast_i;
   logic [AXI_ID_W-1:0]   axi_rid_i;
   logic                  mem_we_o, mem_ready_i;
   logic [MEM_ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0]     mem_wdata_o;
`ifdef IOB_BOOTROM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0]     checksum_o;
`endif

   iob_bootrom_loader #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AXI_ID_W(AXI_ID_W), .AXI_LEN_W(AXI_LEN_W),
      .MEM_ADDR_W(MEM_ADDR_W), .ROM_BASE(0), .BURST_LEN(BURST_LEN)
   ) dut (
      .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i), .start_i(start_i), .nwords_i(nwords_i),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
      .axi_araddr_o(axi_araddr_o), .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
      .axi_arid_o(axi_arid_o), .axi_arlen_o(axi_arlen_o), .axi_arsize_o(axi_arsize_o),
      .axi_arburst_o(axi_arburst_o), .axi_arprot_o(axi_arprot_o), .axi_arlock_o(axi_arlock_o),
      .axi_arcache_o(axi_arcache_o), .axi_arqos_o(axi_arqos_o),
      .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i), .axi_rvalid_i(axi_rvalid_i),
      .axi_rready_o(axi_rready_o), .axi_rid_i(axi_rid_i), .axi_rlast_i(axi_rlast_i),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
`ifdef IOB_BOOTROM_LOADER_CHECKSUM_EN
      .checksum_o(checksum_o),
`endif
      .mem_ready_i(mem_ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int unsigned addr; int unsigned data; } wr_t;
   typedef struct { int unsigned addr; int unsigned len; } ar_t;
   typedef struct { bit err; int unsigned csum; } done_t;

   wr_t   exp_wr[$];
   ar_t   exp_ar[$];
   done_t exp_done[$];
   ar_t   bursts[$];
   logic [31:0] rom [ROM_WORDS];

   int checks, failures, wr_cnt, done_cnt, copy_id;
   int cfg_rdy_mode, cfg_ar_always, cfg_err_beat, cfg_stray;
   bit cfg_early;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rom_word(input int unsigned i);
      logic [8:0] ri;
      ri = 9'(i);
      return rom[ri];
   endfunction

   // Behavioural model: the words, bursts and final status a copy must produce.
   task automatic push_expect(input int unsigned n, output bit err);
      int unsigned ne, off, len;
      wr_t w; ar_t a; done_t d;
      ne = (n > RAM_WORDS) ? RAM_WORDS : n;
      d.csum = 0;
      for (int unsigned i = 0; i < ne; i++) begin
         w.addr = i;
         w.data = rom_word(i);
         d.csum += w.data;
         exp_wr.push_back(w);
      end
      off = 0;
      while (off < ne) begin
         len = ((ne - off) > BURST_LEN) ? BURST_LEN : (ne - off);
         a.addr = (4 * off) % 2048;
         a.len  = len - 1;
         exp_ar.push_back(a);
         off += len;
      end
      err = ((cfg_err_beat >= 0) && (cfg_err_beat < int'(ne))) || (cfg_early && ne >= 2);
      d.err = err;
      exp_done.push_back(d);
   endtask

   // AXI slave: serves accepted bursts from rom with random rvalid gaps.
   initial begin : slave_drv
      int sbeat, gbeat, last_id;
      bit first_burst, r_real, hold;
      ar_t b;
      sbeat = 0; gbeat = 0; last_id = -1; first_burst = 1; r_real = 0; hold = 0;
      axi_arready_i = 1'b0; mem_ready_i = 1'b0; axi_rvalid_i = 1'b0;
      axi_rdata_i = '0; axi_rresp_i = '0; axi_rlast_i = 1'b0; axi_rid_i = '0;
      forever begin
         @(negedge clk);
         if (copy_id != last_id) begin
            last_id = copy_id; gbeat = 0; first_burst = 1;
         end
         axi_arready_i = (cfg_ar_always != 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
         case (cfg_rdy_mode)
            0:       mem_ready_i = 1'b1;
            1:       mem_ready_i = ~mem_ready_i;
            default: mem_ready_i = ($urandom_range(0, 2) != 0);
         endcase
         if (!hold) begin
            if (bursts.size() > 0 && $urandom_range(0, 3) != 0) begin
               b = bursts[0];
               axi_rvalid_i = 1'b1; r_real = 1;
               axi_rdata_i  = rom_word((b.addr >> 2) + sbeat);
               axi_rresp_i  = (gbeat == cfg_err_beat) ? 2'b10 : 2'b00;
               if (cfg_early && first_burst && b.len >= 1) axi_rlast_i = (sbeat == int'(b.len) - 1);
               else axi_rlast_i = (sbeat == int'(b.len));
            end else if (bursts.size() == 0 && cfg_stray != 0 && $urandom_range(0, 1) == 1) begin
               axi_rvalid_i = 1'b1; r_real = 0;
               axi_rdata_i = 32'hDEADBEEF; axi_rresp_i = 2'b00; axi_rlast_i = 1'b1;
            end else begin
               axi_rvalid_i = 1'b0; r_real = 0;
            end
         end
         #2;
         if (rst_i) begin
            bursts.delete(); sbeat = 0; hold = 0; r_real = 0; axi_rvalid_i = 1'b0;
         end else begin
            hold = 0;
            if (axi_rvalid_i && axi_rready_o && r_real) begin
               sbeat++; gbeat++;
               if (sbeat == int'(bursts[0].len) + 1) begin
                  void'(bursts.pop_front()); sbeat = 0; first_burst = 0;
               end
            end else if (axi_rvalid_i && r_real) begin
               hold = 1;
            end
            if (axi_arvalid_o && axi_arready_i) begin
               b.addr = 32'(axi_araddr_o); b.len = 32'(axi_arlen_o);
               bursts.push_back(b);
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a transfer.
   initial begin : monitor
      bit in_data; int beats_left;
      wr_t w; ar_t a; done_t d;
      in_data = 0; beats_left = 0;
      forever begin
         @(negedge clk); #3;
         if (rst_i) begin
            exp_wr.delete(); exp_ar.delete(); exp_done.delete();
            in_data = 0; beats_left = 0;
         end else begin
            chk("rready", 32'(axi_rready_o), 32'(in_data ? mem_ready_i : 1'b0));
            chk("mem_we", 32'(mem_we_o), 32'(in_data & axi_rvalid_i & mem_ready_i));
            if (mem_we_o) begin
               wr_cnt++;
               if (exp_wr.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL ram_write: got write addr %0d data 0x%08h, required none", mem_addr_o, mem_wdata_o);
               end else begin
                  w = exp_wr.pop_front();
                  chk("ram_addr", 32'(mem_addr_o), w.addr);
                  chk("ram_data", mem_wdata_o, w.data);
               end
            end
            if (axi_arvalid_o && axi_arready_i) begin
               chk("ar_during_data", 32'(in_data), 32'd0);
               if (exp_ar.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL ar_burst: got araddr 0x%0h arlen %0d, required none", axi_araddr_o, axi_arlen_o);
               end else begin
                  a = exp_ar.pop_front();
                  chk("araddr", 32'(axi_araddr_o), a.addr);
                  chk("arlen", 32'(axi_arlen_o), a.len);
               end
               chk("arsize", 32'(axi_arsize_o), 32'd2);
               chk("arburst", 32'(axi_arburst_o), 32'd1);
               in_data = 1; beats_left = int'(axi_arlen_o) + 1;
            end else if (in_data && axi_rvalid_i && axi_rready_o) begin
               beats_left--;
               if (beats_left == 0) in_data = 0;
            end
            if (done_o) begin
               done_cnt++;
               if (exp_done.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL done: got done_o=1, required 0");
               end else begin
                  d = exp_done.pop_front();
                  chk("error_at_done", 32'(error_o), 32'(d.err));
                  chk("words_left_at_done", 32'(exp_wr.size()), 32'd0);
                  chk("bursts_left_at_done", 32'(exp_ar.size()), 32'd0);
`ifdef IOB_BOOTROM_LOADER_CHECKSUM_EN
                  chk("checksum", checksum_o, d.csum);
`endif
               end
            end
         end
      end
   end

   task automatic set_cfg(input int rdy, input int ar_al, input int eb, input bit early, input int stray);
      cfg_rdy_mode = rdy; cfg_ar_always = ar_al; cfg_err_beat = eb; cfg_early = early; cfg_stray = stray;
      copy_id++;
   endtask

   task automatic run_copy(input int unsigned n, input bit poke);
      bit exp_err, seen;
      int base;
      push_expect(n, exp_err);
      base = done_cnt;
      @(negedge clk); start_i = 1'b1; nwords_i = 11'(n);
      @(negedge clk); start_i = 1'b0; #1;
      chk("busy_after_start", 32'(busy_o), 32'd1);
      chk("error_cleared", 32'(error_o), 32'd0);
      chk("first_arvalid", 32'(axi_arvalid_o), 32'(n != 0));
      seen = 0;
      for (int c = 0; c < 6000 && !seen; c++) begin
         @(negedge clk);
         if (poke && c == 3 && busy_o) begin
            start_i = 1'b1; nwords_i = 11'($urandom_range(1, 2047));
         end else begin
            start_i = 1'b0;
         end
         #4;
         if (done_cnt != base) seen = 1;
      end
      start_i = 1'b0;
      chk("done_seen", 32'(seen), 32'd1);
      @(negedge clk); #4;
      chk("done_one_cycle", 32'(done_o), 32'd0);
      chk("busy_after_done", 32'(busy_o), 32'd0);
      chk("error_sticky", 32'(error_o), 32'(exp_err));
      chk("done_pulses", 32'(done_cnt - base), 32'd1);
   endtask

   // Stimulus sequence.
   initial begin : stim
      bit e;
      int base;
      checks = 0; failures = 0; wr_cnt = 0; done_cnt = 0; copy_id = 0;
      cfg_rdy_mode = 0; cfg_ar_always = 1; cfg_err_beat = -1; cfg_early = 0; cfg_stray = 0;
      cke_i = 1'b1; rst_i = 1'b1; start_i = 1'b0; nwords_i = '0;
      for (int unsigned i = 0; i < ROM_WORDS; i++) rom[i] = i;
      repeat (3) @(negedge clk);
      #4;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_error", 32'(error_o), 32'd0);
      chk("rst_arvalid", 32'(axi_arvalid_o), 32'd0);
      chk("rst_mem_we", 32'(mem_we_o), 32'd0);
      chk("rst_araddr", 32'(axi_araddr_o), 32'd0);
`ifdef IOB_BOOTROM_LOADER_CHECKSUM_EN
      chk("rst_checksum", checksum_o, 32'd0);
`endif
      @(negedge clk); rst_i = 1'b0;

      // 40 words, data = index, always-ready slave: bursts 15,15,7.
      set_cfg(0, 1, -1, 0, 0);
      run_copy(40, 0);

      // Zero-length copy: no AXI traffic, done two cycles after start.
      set_cfg(0, 1, -1, 0, 1);
      push_expect(0, e);
      @(negedge clk); start_i = 1'b1; nwords_i = '0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk); start_i = 1'b0; #4;
         chk("zero_busy", 32'(busy_o), 32'(k == 1));
         chk("zero_done", 32'(done_o), 32'(k == 2));
         chk("zero_arvalid", 32'(axi_arvalid_o), 32'd0);
      end

      for (int unsigned i = 0; i < ROM_WORDS; i++) rom[i] = $urandom;

      // RAM ready toggling during a 4-beat burst.
      set_cfg(1, 1, -1, 0, 0);
      run_copy(4, 0);

      // Error response on beat 2 plus early rlast, then a clean copy clears it.
      set_cfg(0, 1, 2, 1, 0);
      run_copy(4, 0);
      set_cfg(2, 0, -1, 0, 0);
      run_copy(5, 0);

      // Reset in the middle of a 16-beat burst, then a normal 4-word copy.
      set_cfg(0, 1, -1, 0, 0);
      push_expect(32, e);
      base = wr_cnt;
      @(negedge clk); start_i = 1'b1; nwords_i = 11'd32;
      @(negedge clk); start_i = 1'b0;
      for (int c = 0; c < 200 && (wr_cnt - base) < 4; c++) begin
         @(negedge clk); #4;
      end
      chk("reset_test_reached_beat5", 32'((wr_cnt - base) >= 4), 32'd1);
      @(negedge clk); rst_i = 1'b1;
      @(negedge clk); rst_i = 1'b0; #1;
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_arvalid", 32'(axi_arvalid_o), 32'd0);
      chk("midrst_mem_we", 32'(mem_we_o), 32'd0);
      chk("midrst_error", 32'(error_o), 32'd0);
      set_cfg(2, 0, -1, 0, 1);
      run_copy(4, 0);

      // Checksum pattern 0x11111111*k, k = 1..8.
      for (int unsigned k = 1; k <= 8; k++) rom[k-1] = 32'h11111111 * k;
      set_cfg(0, 1, -1, 0, 0);
      run_copy(8, 0);
`ifdef IOB_BOOTROM_LOADER_CHECKSUM_EN
      chk("checksum_pattern", checksum_o, 32'h66666664);
`endif

      // Randomized copies with stray rvalid and ignored restarts.
      for (int t = 0; t < 10; t++) begin
         for (int unsigned i = 0; i < ROM_WORDS; i++) rom[i] = $urandom;
         set_cfg(2, int'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : -1,
                 ($urandom_range(0, 3) == 0), 1);
         run_copy($urandom_range(1, 80), 1);
      end

      // Oversized request is clamped to the RAM size.
      set_cfg(2, 0, -1, 0, 0);
      run_copy(1025 + $urandom_range(0, 1000), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
